// File: rtl/decode_stage.sv
// RV32I/RV32IM decode stage: decodes on the push edge and buffers decoded
// entries in a DEPTH-deep FIFO with valid/ready handshakes on both sides.
module decode_stage #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 2,
    parameter bit ENABLE_M = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] pc_out,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [XLEN-1:0] immed,
    output logic [2:0]      immedSrc,
    output logic [4:0]      aluOp,
    output logic            illegal
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] SRC_I = 3'd0;
    localparam logic [2:0] SRC_S = 3'd1;
    localparam logic [2:0] SRC_B = 3'd2;
    localparam logic [2:0] SRC_U = 3'd3;
    localparam logic [2:0] SRC_J = 3'd4;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_SLL  = 5'd2;
    localparam logic [4:0] ALU_SLT  = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_OR   = 5'd8;
    localparam logic [4:0] ALU_AND  = 5'd9;
    localparam logic [4:0] ALU_MUL  = 5'd10;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] immed;
        logic [2:0]      src;
        logic [4:0]      alu;
        logic            illegal;
    } entry_t;

    function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    function automatic logic [4:0] base_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    entry_t      dec;

    assign opcode = instr[6:0];
    assign func3  = instr[14:12];
    assign func7  = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'b0};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        dec     = '0;
        dec.pc  = pc;
        dec.rd  = instr[11:7];
        dec.rs1 = instr[19:15];
        dec.rs2 = instr[24:20];
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                dec.src   = SRC_U;
                dec.immed = sext(imm_u);
            end
            OPC_JAL: begin
                dec.src   = SRC_J;
                dec.immed = sext(imm_j);
            end
            OPC_JALR, OPC_LOAD: begin
                dec.src   = SRC_I;
                dec.immed = sext(imm_i);
            end
            OPC_STORE: begin
                dec.src   = SRC_S;
                dec.immed = sext(imm_s);
            end
            OPC_BRANCH: begin
                dec.src   = SRC_B;
                dec.immed = sext(imm_b);
                dec.alu   = ALU_SUB;
            end
            OPC_OP_IMM: begin
                dec.src   = SRC_I;
                dec.immed = sext(imm_i);
                dec.alu   = base_op(func3);
                // Shift immediates carry func7 in the upper imm bits; only SRAI may set bit 30.
                if (func3 == 3'b001 && func7 != 7'b0000000)
                    dec.illegal = 1'b1;
                else if (func3 == 3'b101) begin
                    if (func7 == 7'b0100000)      dec.alu     = ALU_SRA;
                    else if (func7 != 7'b0000000) dec.illegal = 1'b1;
                end
            end
            OPC_OP: begin
                case (func7)
                    7'b0000000: dec.alu = base_op(func3);
                    7'b0100000: begin
                        if (func3 == 3'b000)      dec.alu     = ALU_SUB;
                        else if (func3 == 3'b101) dec.alu     = ALU_SRA;
                        else                      dec.illegal = 1'b1;
                    end
                    7'b0000001: begin
                        if (ENABLE_M) dec.alu     = ALU_MUL + {2'b00, func3};
                        else          dec.illegal = 1'b1;
                    end
                    default: dec.illegal = 1'b1;
                endcase
            end
            OPC_SYSTEM: ;
            default: dec.illegal = 1'b1;
        endcase
        if (dec.illegal) begin
            dec.immed = '0;
            dec.alu   = ALU_ADD;
            dec.src   = SRC_I;
        end
    end

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    logic          push, pop;

    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= dec;
                wptr      <= inc(wptr);
            end
            if (pop) rptr <= inc(rptr);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    assign head     = mem[rptr];
    assign pc_out   = head.pc;
    assign rd       = head.rd;
    assign rs1      = head.rs1;
    assign rs2      = head.rs2;
    assign immed    = head.immed;
    assign immedSrc = head.src;
    assign aluOp    = head.alu;
    assign illegal  = head.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (M enabled / disabled) share stimulus
// and are compared against a queue-based reference decoder.
module tb_decode_stage;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready;
    logic [31:0] instr, pc;

    logic        in_ready_m, out_valid_m, illegal_m;
    logic [31:0] pc_out_m, immed_m;
    logic [4:0]  rd_m, rs1_m, rs2_m, alu_m;
    logic [2:0]  src_m;
    logic        in_ready_n, out_valid_n, illegal_n;
    logic [31:0] pc_out_n, immed_n;
    logic [4:0]  rd_n, rs1_n, rs2_n, alu_n;
    logic [2:0]  src_n;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .DEPTH(DEPTH), .ENABLE_M(1'b1)) dut_m (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_m),
        .instr(instr), .pc(pc), .out_valid(out_valid_m), .out_ready(out_ready),
        .pc_out(pc_out_m), .rd(rd_m), .rs1(rs1_m), .rs2(rs2_m), .immed(immed_m),
        .immedSrc(src_m), .aluOp(alu_m), .illegal(illegal_m)
    );

    decode_stage #(.XLEN(32), .DEPTH(DEPTH), .ENABLE_M(1'b0)) dut_n (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_n),
        .instr(instr), .pc(pc), .out_valid(out_valid_n), .out_ready(out_ready),
        .pc_out(pc_out_n), .rd(rd_n), .rs1(rs1_n), .rs2(rs2_n), .immed(immed_n),
        .immedSrc(src_n), .aluOp(alu_n), .illegal(illegal_n)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] immed;
        logic [2:0]  src;
        logic [4:0]  alu;
        logic        illegal;
    } exp_t;

    exp_t got_m, got_n;
    assign got_m = {pc_out_m, rd_m, rs1_m, rs2_m, immed_m, src_m, alu_m, illegal_m};
    assign got_n = {pc_out_n, rd_n, rs1_n, rs2_n, immed_n, src_n, alu_n, illegal_n};

    logic [63:0] q[$];  // {instr, pc} of accepted, not yet consumed entries
    int checks = 0;
    int errors = 0;

    function automatic exp_t ref_dec(input logic [63:0] ent, input bit men);
        logic [31:0]        i  = ent[63:32];
        logic signed [31:0] si = ent[63:32];
        int  f3 = int'(i[14:12]);
        int  f7 = int'(i[31:25]);
        int  base_map [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        bit  bad = 1'b0;
        exp_t e = '0;
        e.pc  = ent[31:0];
        e.rd  = i[11:7];
        e.rs1 = i[19:15];
        e.rs2 = i[24:20];
        case (i[6:0])
            7'h37, 7'h17: begin e.src = 3'd3; e.immed = i & 32'hFFFFF000; end
            7'h6F: begin
                e.src   = 3'd4;
                e.immed = (32'(si >>> 11) & 32'hFFF00000) | (32'(i[19:12]) << 12)
                        | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
            end
            7'h67, 7'h03: e.immed = 32'(si >>> 20);
            7'h23: begin
                e.src   = 3'd1;
                e.immed = (32'(si >>> 20) & 32'hFFFFFFE0) | 32'(i[11:7]);
            end
            7'h63: begin
                e.src   = 3'd2;
                e.alu   = 5'd1;
                e.immed = (32'(si >>> 19) & 32'hFFFFF000) | (32'(i[7]) << 11)
                        | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
            end
            7'h13: begin
                e.immed = 32'(si >>> 20);
                e.alu   = 5'(base_map[f3]);
                if (f3 == 1 && f7 != 0) bad = 1'b1;
                if (f3 == 5) begin
                    if (f7 == 32)     e.alu = 5'd7;
                    else if (f7 != 0) bad = 1'b1;
                end
            end
            7'h33: begin
                if (f7 == 0)                  e.alu = 5'(base_map[f3]);
                else if (f7 == 32 && f3 == 0) e.alu = 5'd1;
                else if (f7 == 32 && f3 == 5) e.alu = 5'd7;
                else if (f7 == 1 && men)      e.alu = 5'(10 + f3);
                else                          bad = 1'b1;
            end
            7'h73: ;
            default: bad = 1'b1;
        endcase
        if (bad) begin
            e.illegal = 1'b1;
            e.immed   = '0;
            e.alu     = '0;
            e.src     = '0;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
        logic [31:0] w   = $urandom;
        int          sel = $urandom_range(0, 11);
        if (sel < 10) w[6:0] = ops[sel];
        if (w[6:0] == 7'h33 || w[6:0] == 7'h13) begin
            case ($urandom_range(0, 3))
                0: w[31:25] = 7'h00;
                1: w[31:25] = 7'h20;
                2: w[31:25] = 7'h01;
                default: ;
            endcase
        end
        return w;
    endfunction

    // Advance one clock and mirror the handshakes into the reference queue.
    task automatic step();
        bit push, pop;
        push = in_valid && in_ready_m;
        pop  = out_valid_m && out_ready;
        @(posedge clk);
        if (rst) q.delete();
        else begin
            if (pop && q.size() > 0) void'(q.pop_front());
            if (push) q.push_back({instr, pc});
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; instr = '0; pc = '0;
        step(); step();
        rst = 1'b0;
        checks++;
        if (out_valid_m !== 1'b0 || in_ready_m !== 1'b1 || out_valid_n !== 1'b0 || in_ready_n !== 1'b1) begin
            errors++;
            $display("FAIL reset_handshake: out_valid=%b in_ready=%b, expected 0/1", out_valid_m, in_ready_m);
        end
        checks++;
        if (got_m !== '0 || got_n !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h / %h, expected all zero", got_m, got_n);
        end
    endtask

    task automatic test_add();
        out_ready = 1'b1; in_valid = 1'b1; instr = 32'h002081B3; pc = 32'h0000_0100;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid_m !== 1'b1 || rd_m !== 5'd3 || rs1_m !== 5'd1 || rs2_m !== 5'd2 || alu_m !== 5'd0 || illegal_m !== 1'b0) begin
            errors++;
            $display("FAIL add_fields: v=%b rd=%0d rs1=%0d rs2=%0d alu=%0d ill=%b, expected 1 3 1 2 0 0",
                     out_valid_m, rd_m, rs1_m, rs2_m, alu_m, illegal_m);
        end
        checks++;
        if (got_m !== ref_dec({32'h002081B3, 32'h100}, 1'b1)) begin
            errors++;
            $display("FAIL add_model: got %h expected %h", got_m, ref_dec({32'h002081B3, 32'h100}, 1'b1));
        end
        step();
        checks++;
        if (out_valid_m !== 1'b0) begin
            errors++;
            $display("FAIL add_drain: out_valid=%b expected 0", out_valid_m);
        end
    endtask

    task automatic test_imm();
        out_ready = 1'b0; in_valid = 1'b1;
        instr = 32'hFFF00093; pc = 32'h200; step();
        instr = 32'h4032D293; pc = 32'h204; step();
        in_valid = 1'b0;
        checks++;
        if (immed_m !== 32'hFFFFFFFF || src_m !== 3'd0 || alu_m !== 5'd0 || got_m !== ref_dec({32'hFFF00093, 32'h200}, 1'b1)) begin
            errors++;
            $display("FAIL addi_imm: immed=%h src=%0d alu=%0d, expected ffffffff 0 0", immed_m, src_m, alu_m);
        end
        out_ready = 1'b1; step();
        checks++;
        if (alu_m !== 5'd7 || immed_m[4:0] !== 5'd3 || got_m !== ref_dec({32'h4032D293, 32'h204}, 1'b1)) begin
            errors++;
            $display("FAIL srai: alu=%0d shamt=%0d, expected 7 3", alu_m, immed_m[4:0]);
        end
        step();
    endtask

    task automatic test_branch();
        out_ready = 1'b0; in_valid = 1'b1;
        instr = 32'h40208133; pc = 32'h300; step();
        instr = 32'hFE000EE3; pc = 32'h304; step();
        in_valid = 1'b0;
        checks++;
        if (alu_m !== 5'd1 || illegal_m !== 1'b0) begin
            errors++;
            $display("FAIL sub: alu=%0d ill=%b, expected 1 0", alu_m, illegal_m);
        end
        out_ready = 1'b1; step();
        checks++;
        if (alu_m !== 5'd1 || src_m !== 3'd2 || immed_m !== 32'hFFFFFFFC || pc_out_m !== 32'h304) begin
            errors++;
            $display("FAIL beq: alu=%0d src=%0d immed=%h pc=%h, expected 1 2 fffffffc 304", alu_m, src_m, immed_m, pc_out_m);
        end
        step();
    endtask

    task automatic test_mul();
        out_ready = 1'b0; in_valid = 1'b1; instr = 32'h023100B3; pc = 32'h400;
        step();
        in_valid = 1'b0;
        checks++;
        if (alu_m !== 5'd10 || illegal_m !== 1'b0) begin
            errors++;
            $display("FAIL mul_m_on: alu=%0d ill=%b, expected 10 0", alu_m, illegal_m);
        end
        checks++;
        if (alu_n !== 5'd0 || illegal_n !== 1'b1 || immed_n !== 32'h0) begin
            errors++;
            $display("FAIL mul_m_off: alu=%0d ill=%b immed=%h, expected 0 1 0", alu_n, illegal_n, immed_n);
        end
        out_ready = 1'b1; step();
        out_ready = 1'b0; in_valid = 1'b1; instr = 32'h0000007F; pc = 32'h404;
        step();
        in_valid = 1'b0;
        checks++;
        if (illegal_m !== 1'b1 || illegal_n !== 1'b1 || alu_m !== 5'd0 || immed_m !== 32'h0) begin
            errors++;
            $display("FAIL opcode_7f: ill=%b/%b alu=%0d immed=%h, expected 1/1 0 0", illegal_m, illegal_n, alu_m, immed_m);
        end
        out_ready = 1'b1; step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] list [10];
        int k = 0;
        bit acc;
        for (int j = 0; j < 10; j++) list[j] = rand_instr();
        out_ready = 1'b0; in_valid = 1'b1;
        instr = list[0]; pc = 32'h1000; step();
        checks++;
        if (in_ready_m !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: in_ready=%b expected 1", in_ready_m);
        end
        instr = list[1]; pc = 32'h1004; step();
        checks++;
        if (in_ready_m !== 1'b0) begin
            errors++;
            $display("FAIL b2b_full: in_ready=%b expected 0", in_ready_m);
        end
        instr = list[2]; pc = 32'h1008; step();
        checks++;
        if (in_ready_m !== 1'b0 || out_valid_m !== 1'b1 || got_m !== ref_dec({list[0], 32'h1000}, 1'b1)) begin
            errors++;
            $display("FAIL b2b_hold: in_ready=%b head=%h expected 0 / %h", in_ready_m, got_m, ref_dec({list[0], 32'h1000}, 1'b1));
        end
        k = 2;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            acc = in_valid && in_ready_m;
            step();
            if (acc && k < 9) begin
                k++;
                instr = list[k]; pc = 32'h1000 + 32'(4 * k);
            end
            checks++;
            if (out_valid_m !== 1'b1 || in_ready_m !== (q.size() != DEPTH) || got_m !== ref_dec(q[0], 1'b1)) begin
                errors++;
                $display("FAIL b2b_stream: v=%b rdy=%b head=%h expected 1 %b %h", out_valid_m, in_ready_m, got_m,
                         q.size() != DEPTH, ref_dec(q[0], 1'b1));
            end
        end
        in_valid = 1'b0;
        step(); step(); step();
        checks++;
        if (out_valid_m !== 1'b0 || q.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: out_valid=%b expected 0", out_valid_m);
        end
    endtask

    task automatic test_random();
        bit acc;
        in_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                instr    = rand_instr();
                pc       = $urandom & 32'hFFFFFFFC;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            acc = in_valid && in_ready_m;
            step();
            checks++;
            if (out_valid_m !== (q.size() != 0) || in_ready_m !== (q.size() != DEPTH)
                || out_valid_n !== out_valid_m || in_ready_n !== in_ready_m) begin
                errors++;
                $display("FAIL rand_handshake: cycle %0d v=%b rdy=%b expected occupancy %0d", c, out_valid_m, in_ready_m, q.size());
            end
            if (q.size() != 0) begin
                checks++;
                if (got_m !== ref_dec(q[0], 1'b1) || got_n !== ref_dec(q[0], 1'b0)) begin
                    errors++;
                    $display("FAIL rand_head: cycle %0d instr=%h got %h / %h expected %h / %h", c, q[0][63:32],
                             got_m, got_n, ref_dec(q[0], 1'b1), ref_dec(q[0], 1'b0));
                end
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step(); step(); step();
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0; in_valid = 1'b1;
        instr = 32'h00100093; pc = 32'h500; step();
        instr = 32'h00200113; pc = 32'h504; step();
        in_valid = 1'b0; out_ready = 1'b1; step();
        in_valid = 1'b1; instr = 32'h00300193; pc = 32'h508; rst = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid_m !== 1'b0 || in_ready_m !== 1'b1 || got_m !== '0 || got_n !== '0) begin
            errors++;
            $display("FAIL rst_midflight: v=%b rdy=%b data=%h expected 0 1 0", out_valid_m, in_ready_m, got_m);
        end
        step();
        checks++;
        if (out_valid_m !== 1'b0 || out_valid_n !== 1'b0) begin
            errors++;
            $display("FAIL rst_discard: out_valid=%b/%b expected 0", out_valid_m, out_valid_n);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_imm();
        test_branch();
        test_mul();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
